// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter
//   Shares the single-port SPI data memory between two requesters:
//   port 0 = SPI transaction FSM (priority), port 1 = FPGA-side host.
//   A starvation guard forces a port-1 grant after STARVE_MAX consecutive
//   port-0 grants made while port 1 was waiting.
//   Each access is IDLE -> ACCESS -> RESP, one cycle per state.
// Ports
//   clk, rst_n                     clock, async active-low reset
//   req*/we*/addr*/wdata*          requester inputs, held until ack*
//   ack*                           1-cycle completion pulse
//   rdata*                         read data, valid with ack*, held until next access
//   mem_addr/mem_din/mem_we        registered drive to the data memory
//   mem_dout                       combinational read data from the memory
//   busy, owner                    access in progress / port being served
module spi_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy,
  output logic                  owner
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state,      w_state_nxt;
  logic [CNT_W-1:0]      r_starve_cnt, w_starve_nxt;
  logic                  r_owner,      w_owner_nxt;
  logic                  r_busy,       w_busy_nxt;
  logic                  r_ack0,       w_ack0_nxt;
  logic                  r_ack1,       w_ack1_nxt;
  logic [DATA_WIDTH-1:0] r_rdata0,     w_rdata0_nxt;
  logic [DATA_WIDTH-1:0] r_rdata1,     w_rdata1_nxt;
  logic                  r_mem_we,     w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem_din,    w_mem_din_nxt;
  logic                  w_pick1;

  // State and output registers; reset drops mem_we at once, aborting any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_owner      <= 1'b0;
      r_busy       <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_owner      <= w_owner_nxt;
      r_busy       <= w_busy_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
      r_rdata0     <= w_rdata0_nxt;
      r_rdata1     <= w_rdata1_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_din    <= w_mem_din_nxt;
    end
  end

  // Next-state and next-output logic.
  // The mem_addr/mem_din/mem_we registers double as the latched request:
  // they are loaded with the winner's fields on the IDLE->ACCESS edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_starve_nxt   = r_starve_cnt;
    w_owner_nxt    = r_owner;
    w_busy_nxt     = r_busy;
    w_ack0_nxt     = 1'b0;
    w_ack1_nxt     = 1'b0;
    w_rdata0_nxt   = r_rdata0;
    w_rdata1_nxt   = r_rdata1;
    w_mem_we_nxt   = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_din_nxt  = r_mem_din;
    w_pick1        = req1 && (!req0 || (r_starve_cnt == STARVE_LIM));

    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_state_nxt = S_ACCESS;
          w_busy_nxt  = 1'b1;
          w_owner_nxt = w_pick1;
          if (w_pick1) begin
            w_mem_we_nxt   = we1;
            w_mem_addr_nxt = addr1;
            w_mem_din_nxt  = wdata1;
            w_starve_nxt   = '0;
          end else begin
            w_mem_we_nxt   = we0;
            w_mem_addr_nxt = addr0;
            w_mem_din_nxt  = wdata0;
            // Count only grants that made port 1 wait; saturate at the limit.
            if (!req1) begin
              w_starve_nxt = '0;
            end else if (r_starve_cnt < STARVE_LIM) begin
              w_starve_nxt = r_starve_cnt + CNT_W'(1);
            end
          end
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_RESP;
        // r_mem_we is the latched write flag; reads capture into the owner only.
        if (!r_mem_we) begin
          if (r_owner) w_rdata1_nxt = mem_dout;
          else         w_rdata0_nxt = mem_dout;
        end
        if (r_owner) w_ack1_nxt = 1'b1;
        else         w_ack0_nxt = 1'b1;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign busy     = r_busy;
  assign owner    = r_owner;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter with a behavioural memory and an
// ack scoreboard (expected port / rdata pushed when a request is driven).
module tb_spi_mem_arbiter;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_we, busy, owner;

  always #5 clk = ~clk;

  spi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .busy(busy), .owner(owner)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i) ^ 8'hC3;
  endfunction

  // Behavioural single-port memory: combinational read, write on posedge.
  logic [DW-1:0] mem [0:127];
  bit            mem_fill;
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end
  assign mem_dout = mem[mem_addr];

  typedef struct {
    bit            port;
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  logic [DW-1:0] ref_mem [0:127];
  logic [DW-1:0] exp_r0, exp_r1;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of an access, in service order.
  task automatic push_exp(input bit port, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    if (we) ref_mem[addr] = wdata;
    else if (port) exp_r1 = ref_mem[addr];
    else exp_r0 = ref_mem[addr];
    sb.push_back('{port, exp_r0, exp_r1});
  endtask

  // Advance to the next negedge and run the ack / mem_we monitor there.
  task automatic step();
    @(negedge clk);
    if (ack0 || ack1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'({ack1, ack0}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_port", 32'({ack1, ack0}), e.port ? 32'd2 : 32'd1);
        check("rdata0", 32'(rdata0), 32'(e.r0));
        check("rdata1", 32'(rdata1), 32'(e.r1));
      end
    end
    if (mem_we) check("we_only_busy", 32'(busy), 32'd1);
  endtask

  // One access on one port; observes a fixed 6-cycle window from request.
  task automatic do_access(input bit port, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int drop_k,
                           output int ack_k, output int we_cyc, output int ack_cnt,
                           output int busy_cyc);
    logic a;
    push_exp(port, we, addr, wdata);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    ack_k = 0; we_cyc = 0; ack_cnt = 0; busy_cyc = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      a = port ? ack1 : ack0;
      if (mem_we) we_cyc++;
      if (busy) begin
        busy_cyc++;
        check("owner", 32'(owner), 32'(port));
      end
      if (a) begin
        ack_cnt++;
        if (ack_k == 0) ack_k = k;
      end
      if (a || k == drop_k) begin
        if (port) req1 = 1'b0; else req0 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ak, wc, ac, bc, a0k, a1k, overlap, n0, n1, first1;
    bit pat [10];

    rst_n = 1'b0; mem_fill = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    exp_r0 = '0; exp_r1 = '0;
    repeat (2) @(posedge clk);
    #1 mem_fill = 1'b0;

    // Reset state
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_rdata0", 32'(rdata0), 32'd0);
    check("rst_rdata1", 32'(rdata1), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the ACCESS cycle of a write aborts it
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h10; wdata0 = 8'hA5;
    @(posedge clk); #1;
    check("abort_we_before", 32'(mem_we), 32'd1);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_we_after", 32'(mem_we), 32'd0);
    check("abort_busy_after", 32'(busy), 32'd0);
    req0 = 1'b0; we0 = 1'b0;
    step();
    check("abort_no_ack", 32'({ack1, ack0}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) step();
    check("abort_mem10", 32'(mem[7'h10]), 32'(init_val(16)));
    @(posedge clk); #1;

    // Port-0 write then read back
    do_access(1'b0, 1'b1, 7'h05, 8'h3C, 0, ak, wc, ac, bc);
    check("wr_ack_cycle", 32'(ak), 32'd3);
    check("wr_we_cycles", 32'(wc), 32'd1);
    check("wr_ack_pulses", 32'(ac), 32'd1);
    check("wr_busy_cycles", 32'(bc), 32'd2);
    do_access(1'b0, 1'b0, 7'h05, 8'h00, 0, ak, wc, ac, bc);
    check("rd_ack_cycle", 32'(ak), 32'd3);
    check("rd_we_cycles", 32'(wc), 32'd0);
    check("rd_rdata0", 32'(rdata0), 32'h3C);

    // Simultaneous reads: port 0 first, port 1 three cycles later
    push_exp(1'b0, 1'b0, 7'h20, 8'h00);
    push_exp(1'b1, 1'b0, 7'h21, 8'h00);
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h20;
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'h21;
    a0k = 0; a1k = 0; overlap = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (ack0 && ack1) overlap++;
      if (ack0) begin if (a0k == 0) a0k = k; req0 = 1'b0; end
      if (ack1) begin if (a1k == 0) a1k = k; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("sim_ack0_cycle", 32'(a0k), 32'd3);
    check("sim_ack1_cycle", 32'(a1k), 32'd6);
    check("sim_overlap", 32'(overlap), 32'd0);
    @(posedge clk); #1;

    // Both held: four port-0 grants, one port-1 grant, repeating
    pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++)
      push_exp(pat[i], 1'b0, pat[i] ? 7'h31 : 7'h30, 8'h00);
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h30;
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'h31;
    n0 = 0; n1 = 0; first1 = 0; overlap = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (ack0 && ack1) overlap++;
      if (ack0) n0++;
      if (ack1) begin n1++; if (first1 == 0) first1 = k; end
      if (k == 30) begin req0 = 1'b0; req1 = 1'b0; end
    end
    check("starve_p0_grants", 32'(n0), 32'd8);
    check("starve_p1_grants", 32'(n1), 32'd2);
    check("starve_first_p1", 32'(first1), 32'd15);
    check("starve_overlap", 32'(overlap), 32'd0);
    step();
    step();
    check("starve_idle_after", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Port-1 read of top address leaves rdata0 alone
    do_access(1'b0, 1'b1, 7'h40, 8'h11, 0, ak, wc, ac, bc);
    do_access(1'b0, 1'b0, 7'h40, 8'h00, 0, ak, wc, ac, bc);
    do_access(1'b1, 1'b0, 7'h7F, 8'h00, 0, ak, wc, ac, bc);
    check("p1_ack_cycle", 32'(ak), 32'd3);
    check("p1_rdata1", 32'(rdata1), 32'(init_val(127)));
    check("p1_rdata0_kept", 32'(rdata0), 32'h11);

    // req1 dropped during ACCESS: write still lands, single ack, no re-grant
    do_access(1'b1, 1'b1, 7'h50, 8'h99, 2, ak, wc, ac, bc);
    check("drop_ack_pulses", 32'(ac), 32'd1);
    check("drop_we_cycles", 32'(wc), 32'd1);
    check("drop_busy_cycles", 32'(bc), 32'd2);
    check("drop_mem50", 32'(mem[7'h50]), 32'h99);
    do_access(1'b0, 1'b0, 7'h50, 8'h00, 0, ak, wc, ac, bc);
    check("drop_readback", 32'(rdata0), 32'h99);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
